// File: rtl/rhs_stim_sequencer.sv
// RHS stimulation train sequencer: turns a latched pulse configuration into timed RHS register writes.
// Optional charge-recovery writes after each pulse are enabled by defining RHS_STIM_CHARGE_RECOVERY_EN.
module rhs_stim_sequencer #(
  parameter int CNT_W    = 16,
  parameter int NPULSE_W = 8
) (
  input  logic                rhs_aclk,
  input  logic                areset,
  input  logic                sample_tick,
  input  logic                trigger,
  input  logic                abort,
  input  logic [4:0]          cfg_pos_ch,
  input  logic [4:0]          cfg_neg_ch,
  input  logic                cfg_monopolar,
  input  logic [CNT_W-1:0]    cfg_pulse_width,
  input  logic [CNT_W-1:0]    cfg_ipd,
  input  logic [NPULSE_W-1:0] cfg_num_pulse,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic [7:0]          cmd_addr,
  output logic [15:0]         cmd_data_a,
  output logic [15:0]         cmd_data_b,
  output logic                busy,
  output logic                done,
  output logic [NPULSE_W-1:0] pulse_idx
);

  localparam logic [7:0] ADDR_POL  = 8'd34;
  localparam logic [7:0] ADDR_STIM = 8'd32;
  localparam logic [7:0] ADDR_REC  = 8'd48;

  typedef enum logic [3:0] {
    S_IDLE, S_POL1, S_ON, S_PH1, S_POL2, S_PH2, S_OFF, S_GAP
`ifdef RHS_STIM_CHARGE_RECOVERY_EN
    , S_REC_ON, S_REC_WAIT, S_REC_OFF
`endif
  } state_t;

  state_t              state_q, state_d, gap_state;
  logic [CNT_W-1:0]    cnt_q, cnt_d, width_eff;
  logic [NPULSE_W-1:0] idx_q, idx_d;
  logic                abort_q, abort_d;
  logic                hs, abt;

  logic [4:0]          pos_q, neg_q, pos_s, neg_s;
  logic                mono_q, mono_s;
  logic [CNT_W-1:0]    width_q, ipd_q;
  logic [NPULSE_W-1:0] num_q;
  logic [31:0]         p1, p2, mask;

  logic                cmd_valid_q, cmd_valid_d;
  logic [7:0]          cmd_addr_q, cmd_addr_d;
  logic [31:0]         cmd_data_q, cmd_data_d;
  logic                busy_q, busy_d, done_q, done_d;

  assign cmd_valid  = cmd_valid_q;
  assign cmd_addr   = cmd_addr_q;
  assign cmd_data_a = cmd_data_q[15:0];
  assign cmd_data_b = cmd_data_q[31:16];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pulse_idx  = idx_q;

  always_ff @(posedge rhs_aclk or posedge areset) begin
    if (areset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      abort_q     <= 1'b0;
      pos_q       <= '0;
      neg_q       <= '0;
      mono_q      <= 1'b0;
      width_q     <= '0;
      ipd_q       <= '0;
      num_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      abort_q     <= abort_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_data_q  <= cmd_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      if (state_q == S_IDLE && trigger) begin
        pos_q   <= cfg_pos_ch;
        neg_q   <= cfg_neg_ch;
        mono_q  <= cfg_monopolar;
        width_q <= cfg_pulse_width;
        ipd_q   <= cfg_ipd;
        num_q   <= cfg_num_pulse;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    hs        = cmd_valid_q & cmd_ready;
    abt       = abort | abort_q;
    width_eff = (width_q == '0) ? CNT_W'(1) : width_q;
    // End-of-pulse decision shared by OFF and (when compiled) REC_OFF
    if (idx_q == num_q)     gap_state = S_IDLE;
    else if (ipd_q == '0)   gap_state = S_POL1;
    else                    gap_state = S_GAP;

    case (state_q)
      S_IDLE: if (trigger) begin
        state_d = S_POL1;
        idx_d   = '0;
      end
      S_POL1: if (hs) state_d = abt ? S_OFF : S_ON;
      S_ON:   if (hs) state_d = abt ? S_OFF : S_PH1;
      S_PH1: begin
        if (abt)                    state_d = S_OFF;
        else if (cnt_q == '0)       state_d = S_POL2;
        else if (sample_tick)       cnt_d   = cnt_q - CNT_W'(1);
      end
      S_POL2: if (hs) state_d = abt ? S_OFF : S_PH2;
      S_PH2: begin
        if (abt)                    state_d = S_OFF;
        else if (cnt_q == '0)       state_d = S_OFF;
        else if (sample_tick)       cnt_d   = cnt_q - CNT_W'(1);
      end
      S_OFF: if (hs) begin
        if (abt) state_d = S_IDLE;
        else begin
`ifdef RHS_STIM_CHARGE_RECOVERY_EN
          state_d = S_REC_ON;
`else
          state_d = gap_state;
          if (gap_state == S_POL1) idx_d = idx_q + NPULSE_W'(1);
`endif
        end
      end
      S_GAP: begin
        if (abt) state_d = S_OFF;
        else if (cnt_q == '0) begin
          state_d = S_POL1;
          idx_d   = idx_q + NPULSE_W'(1);
        end else if (sample_tick) cnt_d = cnt_q - CNT_W'(1);
      end
`ifdef RHS_STIM_CHARGE_RECOVERY_EN
      S_REC_ON: if (hs) state_d = abt ? S_OFF : S_REC_WAIT;
      S_REC_WAIT: begin
        if (abt)                    state_d = S_OFF;
        else if (cnt_q == '0)       state_d = S_REC_OFF;
        else if (sample_tick)       cnt_d   = cnt_q - CNT_W'(1);
      end
      S_REC_OFF: if (hs) begin
        if (abt) state_d = S_OFF;
        else begin
          state_d = gap_state;
          if (gap_state == S_POL1) idx_d = idx_q + NPULSE_W'(1);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Counters load on entry so a tick coinciding with entry is not counted
    if (state_d != state_q) begin
      case (state_d)
        S_PH1, S_PH2: cnt_d = width_eff;
        S_GAP:        cnt_d = ipd_q;
`ifdef RHS_STIM_CHARGE_RECOVERY_EN
        S_REC_WAIT:   cnt_d = CNT_W'(1);
`endif
        default: ;
      endcase
    end

    abort_d = abort_q;
    if (state_d == S_IDLE)                   abort_d = 1'b0;
    else if (state_q != S_IDLE && abort)     abort_d = 1'b1;
  end

  // Outputs are registered from the next state; the config source is the live inputs only on the trigger cycle
  always_comb begin
    pos_s       = (state_q == S_IDLE) ? cfg_pos_ch    : pos_q;
    neg_s       = (state_q == S_IDLE) ? cfg_neg_ch    : neg_q;
    mono_s      = (state_q == S_IDLE) ? cfg_monopolar : mono_q;
    p1          = 32'd1 << pos_s;
    p2          = mono_s ? 32'd0 : (32'd1 << neg_s);
    mask        = p1 | p2;
    cmd_valid_d = 1'b0;
    cmd_addr_d  = cmd_addr_q;
    cmd_data_d  = cmd_data_q;
    case (state_d)
      S_POL1: begin cmd_valid_d = 1'b1; cmd_addr_d = ADDR_POL;  cmd_data_d = p1;    end
      S_ON:   begin cmd_valid_d = 1'b1; cmd_addr_d = ADDR_STIM; cmd_data_d = mask;  end
      S_POL2: begin cmd_valid_d = 1'b1; cmd_addr_d = ADDR_POL;  cmd_data_d = p2;    end
      S_OFF:  begin cmd_valid_d = 1'b1; cmd_addr_d = ADDR_STIM; cmd_data_d = '0;    end
`ifdef RHS_STIM_CHARGE_RECOVERY_EN
      S_REC_ON:  begin cmd_valid_d = 1'b1; cmd_addr_d = ADDR_REC; cmd_data_d = mask; end
      S_REC_OFF: begin cmd_valid_d = 1'b1; cmd_addr_d = ADDR_REC; cmd_data_d = '0;   end
`endif
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_q != S_IDLE) && (state_d == S_IDLE);
  end

endmodule

// File: tb/tb_rhs_stim_sequencer.sv
// Scoreboard bench for rhs_stim_sequencer: a train-level model pushes expected writes, a monitor checks handshakes.
module tb_rhs_stim_sequencer;
  localparam int CNT_W    = 16;
  localparam int NPULSE_W = 8;
`ifdef RHS_STIM_CHARGE_RECOVERY_EN
  localparam int CMDS_PER = 6;
`else
  localparam int CMDS_PER = 4;
`endif

  logic                clk = 1'b0;
  logic                areset, sample_tick, trigger, abort, cfg_monopolar, cmd_ready;
  logic [4:0]          cfg_pos_ch, cfg_neg_ch;
  logic [CNT_W-1:0]    cfg_pulse_width, cfg_ipd;
  logic [NPULSE_W-1:0] cfg_num_pulse, pulse_idx;
  logic                cmd_valid, busy, done;
  logic [7:0]          cmd_addr;
  logic [15:0]         cmd_data_a, cmd_data_b;

  rhs_stim_sequencer #(.CNT_W(CNT_W), .NPULSE_W(NPULSE_W)) dut (
    .rhs_aclk(clk), .areset(areset), .sample_tick(sample_tick), .trigger(trigger), .abort(abort),
    .cfg_pos_ch(cfg_pos_ch), .cfg_neg_ch(cfg_neg_ch), .cfg_monopolar(cfg_monopolar),
    .cfg_pulse_width(cfg_pulse_width), .cfg_ipd(cfg_ipd), .cfg_num_pulse(cfg_num_pulse),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_data_a(cmd_data_a), .cmd_data_b(cmd_data_b), .busy(busy), .done(done), .pulse_idx(pulse_idx)
  );

  always #9 clk = ~clk;

  typedef struct {
    bit          is_done;
    logic [7:0]  addr;
    logic [31:0] data;
    int          ticks;   // ticks expected since previous write, -1 = don't care
    int          idx;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0;
  int   tick_per = 10, hold = 0, hs_total = 0;
  bit   rnd_ready = 1'b0, stall_on = 1'b0;

  function automatic void chk(string name, longint act, longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic void push(bit d, logic [7:0] a, logic [31:0] v, int t, int i);
    exp_t e;
    e.is_done = d; e.addr = a; e.data = v; e.ticks = t; e.idx = i;
    sb.push_back(e);
  endfunction

  // Train model: write sequence derived from the pulse rules, not from any state encoding
  function automatic void model_train(int pos, int neg, bit mono, int w, int ipd, int num, bit early_abort);
    logic [31:0] p1, p2, m;
    int we;
    p1 = 32'd1 << pos;
    p2 = mono ? 32'd0 : (32'd1 << neg);
    m  = p1 | p2;
    we = (w == 0) ? 1 : w;
    for (int p = 0; p <= num; p++) begin
      push(0, 8'd34, p1, (p == 0) ? -1 : ipd, p);
      push(0, 8'd32, m, 0, p);
      if (early_abort) begin
        push(0, 8'd32, 32'd0, -1, p);
        push(1, 8'd0, 32'd0, -1, p);
        return;
      end
      push(0, 8'd34, p2, we, p);
      push(0, 8'd32, 32'd0, we, p);
`ifdef RHS_STIM_CHARGE_RECOVERY_EN
      push(0, 8'd48, m, 0, p);
      push(0, 8'd48, 32'd0, 1, p);
`endif
    end
    push(1, 8'd0, 32'd0, -1, num);
  endfunction

  initial begin
    int tcnt;
    tcnt = 0;
    sample_tick = 1'b0;
    forever begin
      @(posedge clk); #1;
      tcnt++;
      if (tcnt >= tick_per) begin sample_tick = 1'b1; tcnt = 0; end
      else sample_tick = 1'b0;
    end
  end

  initial begin
    cmd_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (hold > 0) begin
        hold--;
        cmd_ready = 1'b0;
      end else if (stall_on && cmd_valid && cmd_addr == 8'd32 && {cmd_data_b, cmd_data_a} != 32'd0) begin
        stall_on  = 1'b0;
        hold      = 49;
        cmd_ready = 1'b0;
      end else begin
        cmd_ready = rnd_ready ? ($urandom_range(3) != 0) : 1'b1;
      end
    end
  end

  // Monitor: ticks are counted only in cycles with no command pending
  initial begin
    bit          prev_stall;
    logic [39:0] prev_word;
    int          tick_cnt;
    exp_t        e;
    prev_stall = 1'b0; prev_word = '0; tick_cnt = 0;
    forever begin
      @(negedge clk);
      if (areset) begin
        prev_stall = 1'b0;
        tick_cnt   = 0;
        continue;
      end
      if (sample_tick && !cmd_valid) tick_cnt++;
      if (prev_stall) begin
        chk("stall_valid", cmd_valid, 1);
        chk("stall_word", {cmd_addr, cmd_data_b, cmd_data_a}, prev_word);
      end
      if (cmd_valid && cmd_ready) begin
        hs_total++;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_cmd: got addr %0d data 0x%0h, expected none", cmd_addr, {cmd_data_b, cmd_data_a});
        end else begin
          e = sb.pop_front();
          chk("cmd_kind", 0, e.is_done);
          chk("cmd_addr", cmd_addr, e.addr);
          chk("cmd_data", {cmd_data_b, cmd_data_a}, e.data);
          chk("cmd_idx", pulse_idx, e.idx);
          if (e.ticks >= 0) chk("cmd_ticks", tick_cnt, e.ticks);
        end
        tick_cnt = 0;
      end
      if (done) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done with idx %0d, expected none", pulse_idx);
        end else begin
          e = sb.pop_front();
          chk("done_kind", 1, e.is_done);
          chk("done_idx", pulse_idx, e.idx);
        end
      end
      prev_stall = cmd_valid && !cmd_ready;
      prev_word  = {cmd_addr, cmd_data_b, cmd_data_a};
    end
  end

  task automatic start_train(input int pos, input int neg, input bit mono, input int w, input int ipd,
                             input int num, input bit early_abort, input bit with_abort);
    model_train(pos, neg, mono, w, ipd, num, early_abort);
    @(posedge clk); #1;
    cfg_pos_ch = 5'(pos); cfg_neg_ch = 5'(neg); cfg_monopolar = mono;
    cfg_pulse_width = CNT_W'(w); cfg_ipd = CNT_W'(ipd); cfg_num_pulse = NPULSE_W'(num);
    trigger = 1'b1; abort = with_abort;
    @(posedge clk); #1;
    trigger = 1'b0; abort = 1'b0;
    chk("busy_rise", busy, 1);
    chk("valid_rise", cmd_valid, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 30000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", sb.size(), 0);
    chk("idle_busy", busy, 0);
    sb.delete();
  endtask

  task automatic wait_hs(input int base, input int cnt);
    int n;
    n = 0;
    while (hs_total - base < cnt && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("hs_reached", (hs_total - base) >= cnt, 1);
  endtask

  initial begin
    int base;
    areset = 1'b1; trigger = 1'b0; abort = 1'b0;
    cfg_pos_ch = '0; cfg_neg_ch = '0; cfg_monopolar = 1'b0;
    cfg_pulse_width = '0; cfg_ipd = '0; cfg_num_pulse = '0;
    repeat (3) @(posedge clk);
    #1 areset = 1'b0;
    @(negedge clk);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_addr", cmd_addr, 0);
    chk("rst_data", {cmd_data_b, cmd_data_a}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_idx", pulse_idx, 0);

    // abort alone in IDLE must do nothing
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_valid", cmd_valid, 0);

    tick_per = 200;
    start_train(17, 18, 0, 1, 16, 1, 0, 0);
    wait_idle();
    chk("idx_end_t1", pulse_idx, 1);

    tick_per = 10;
    start_train(3, 9, 1, 2, 1, 1, 0, 0);
    wait_idle();

    tick_per = 20; stall_on = 1'b1;
    start_train(12, 25, 0, 3, 2, 0, 0, 0);
    wait_idle();

    tick_per = 20;
    base = hs_total;
    start_train(5, 9, 0, 5, 3, 7, 1, 0);
    wait_hs(base, 2);
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    wait_idle();
    chk("idx_end_abort", pulse_idx, 0);

    // trigger and abort together in IDLE: trigger wins
    tick_per = 8;
    start_train(0, 31, 0, 0, 0, 2, 0, 1);
    wait_idle();
    chk("idx_end_zero", pulse_idx, 2);

    rnd_ready = 1'b1;
    for (int it = 0; it < 8; it++) begin
      int num;
      tick_per = $urandom_range(30, 4);
      num = $urandom_range(3);
      start_train($urandom_range(31), $urandom_range(31), 1'($urandom_range(1)),
                  $urandom_range(6), $urandom_range(6), num, 0, 0);
      repeat ($urandom_range(60, 5)) @(posedge clk);
      #1;
      if (busy) begin
        cfg_pos_ch = 5'($urandom_range(31)); cfg_neg_ch = 5'($urandom_range(31));
        cfg_pulse_width = CNT_W'($urandom_range(9)); cfg_num_pulse = NPULSE_W'($urandom_range(9));
        trigger = 1'b1;
        @(posedge clk); #1 trigger = 1'b0;
      end
      wait_idle();
      chk("idx_end_rnd", pulse_idx, num);
    end
    rnd_ready = 1'b0;

    // asynchronous reset during PH2 of pulse 1
    tick_per = 20;
    base = hs_total;
    start_train(2, 20, 0, 10, 1, 2, 0, 0);
    wait_hs(base, CMDS_PER + 3);
    repeat (5) @(posedge clk);
    #4 areset = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", cmd_valid, 0);
    chk("arst_idx", pulse_idx, 0);
    chk("arst_addr", cmd_addr, 0);
    @(posedge clk); #1 areset = 1'b0;
    sb.delete();
    repeat (4) @(negedge clk);
    chk("arst_stays_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
